// File: rtl/round_sequencer.sv
// Round FSM (LOAD/ADJUST/WAIT_PRIME/WAIT_GUESS/SCORE) with Moore outputs; define ROUND_PENALTY_EN to subtract POINTS on a wrong guess.
// Latency: 5 cycles per round at best; no backpressure: waits up to PRIME_TIMEOUT for findPrimeDone and indefinitely for guessValid.
module round_sequencer #(
    parameter int NUM_ROUNDS    = 10,
    parameter int POINTS        = 5,
    parameter int PRIME_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startGame,
    input  logic [6:0] randomNumber,
    input  logic       findPrimeDone,
    input  logic       isPrime,
    input  logic       guessValid,
    input  logic       guessIsPrime,
    output logic       levelAdjustEnable,
    output logic [6:0] primeNumberOut,
    output logic [6:0] score,
    output logic [3:0] round,
    output logic       busy,
    output logic       gameOver
);
    typedef enum logic [2:0] {
        IDLE, LOAD, ADJUST, WAIT_PRIME, WAIT_GUESS, SCORE, DONE
    } state_t;

    localparam logic [7:0] PTS      = 8'(POINTS);
    localparam logic [8:0] MAX_SC   = 9'd99;
    localparam logic [7:0] TMO_LAST = 8'(PRIME_TIMEOUT - 1);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [6:0] prime_q, prime_d;
    logic [6:0] score_q, score_d;
    logic [3:0] round_q, round_d;
    logic [7:0] cnt_q, cnt_d;
    logic       verdict_q, verdict_d;
    logic       guess_q, guess_d;
    logic       missed_q, missed_d;

    logic [8:0] score_sum;
    logic [6:0] score_up;
    logic [3:0] round_inc;

    assign score_sum = {2'b00, score_q} + {1'b0, PTS};
    assign score_up  = (score_sum > MAX_SC) ? 7'd99 : 7'(score_sum);
    assign round_inc = round_q + 4'd1;

`ifdef ROUND_PENALTY_EN
    logic [6:0] score_dn;
    assign score_dn = ({1'b0, score_q} < PTS) ? 7'd0 : 7'({1'b0, score_q} - PTS);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prime_q   <= '0;
            score_q   <= '0;
            round_q   <= '0;
            cnt_q     <= '0;
            verdict_q <= 1'b0;
            guess_q   <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prime_q   <= prime_d;
            score_q   <= score_d;
            round_q   <= round_d;
            cnt_q     <= cnt_d;
            verdict_q <= verdict_d;
            guess_q   <= guess_d;
            missed_q  <= missed_d;
        end
    end

    // A checker verdict arriving on the final wait cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (startGame) state_d = LOAD;
            LOAD:       state_d = ADJUST;
            ADJUST:     state_d = WAIT_PRIME;
            WAIT_PRIME: begin
                if (findPrimeDone)          state_d = WAIT_GUESS;
                else if (cnt_q == TMO_LAST) state_d = SCORE;
            end
            WAIT_GUESS: if (guessValid) state_d = SCORE;
            SCORE:      state_d = (round_inc == LAST_RND) ? DONE : LOAD;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        prime_d   = prime_q;
        score_d   = score_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        verdict_d = verdict_q;
        guess_d   = guess_q;
        missed_d  = missed_q;
        case (state_q)
            IDLE, DONE: begin
                if (startGame) begin
                    score_d = '0;
                    round_d = '0;
                end
            end
            LOAD:   prime_d = randomNumber;
            ADJUST: begin
                cnt_d    = '0;
                missed_d = 1'b0;
            end
            WAIT_PRIME: begin
                if (findPrimeDone)          verdict_d = isPrime;
                else if (cnt_q == TMO_LAST) missed_d  = 1'b1;
                else                        cnt_d     = cnt_q + 8'd1;
            end
            WAIT_GUESS: if (guessValid) guess_d = guessIsPrime;
            SCORE: begin
                round_d = round_inc;
                // A missed round never touches the score.
                if (!missed_q) begin
                    if (guess_q == verdict_q) score_d = score_up;
`ifdef ROUND_PENALTY_EN
                    else                      score_d = score_dn;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        levelAdjustEnable = 1'b0;
        busy              = 1'b1;
        gameOver          = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            ADJUST:  levelAdjustEnable = 1'b1;
            DONE: begin
                busy     = 1'b0;
                gameOver = 1'b1;
            end
            default: ;
        endcase
    end

    assign primeNumberOut = prime_q;
    assign score          = score_q;
    assign round          = round_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a default instance plus a 40-point, 15-round instance for saturation.
module tb_round_sequencer;
    logic       clk, rst, startGame, findPrimeDone, isPrime, guessValid, guessIsPrime;
    logic [6:0] randomNumber;
    logic       levelAdjustEnable, busy, gameOver;
    logic [6:0] primeNumberOut, score;
    logic [3:0] round;
    logic       lae_b, busy_b, go_b;
    logic [6:0] pn_b, score_b;
    logic [3:0] round_b;

    int errors = 0;
    int checks = 0;
    int adj_pulses = 0;
    int adj_pulses_b = 0;

`ifdef ROUND_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    round_sequencer dut (
        .clk(clk), .rst(rst), .startGame(startGame), .randomNumber(randomNumber),
        .findPrimeDone(findPrimeDone), .isPrime(isPrime), .guessValid(guessValid),
        .guessIsPrime(guessIsPrime), .levelAdjustEnable(levelAdjustEnable),
        .primeNumberOut(primeNumberOut), .score(score), .round(round),
        .busy(busy), .gameOver(gameOver)
    );

    round_sequencer #(.NUM_ROUNDS(15), .POINTS(40), .PRIME_TIMEOUT(15)) dut_b (
        .clk(clk), .rst(rst), .startGame(startGame), .randomNumber(randomNumber),
        .findPrimeDone(findPrimeDone), .isPrime(isPrime), .guessValid(guessValid),
        .guessIsPrime(guessIsPrime), .levelAdjustEnable(lae_b),
        .primeNumberOut(pn_b), .score(score_b), .round(round_b),
        .busy(busy_b), .gameOver(go_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (levelAdjustEnable) adj_pulses++;
        if (lae_b) adj_pulses_b++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Drives one round starting from LOAD (or the cycle before); d=0 means no checker answer.
    task automatic play_round(input logic [6:0] num, input int d, input logic v, input logic g,
                              input int gdly, input logic spur,
                              output logic tmo, output logic [6:0] pn_seen);
        int n;
        tmo = 1'b0;
        pn_seen = '0;
        randomNumber = num;
        n = 0;
        while (levelAdjustEnable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (levelAdjustEnable !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        pn_seen = primeNumberOut;
        @(negedge clk);
        if (d == 0) begin
            repeat (16) @(negedge clk);
            return;
        end
        if (spur) begin
            guessValid = 1'b1; guessIsPrime = ~g;
            @(negedge clk);
            guessValid = 1'b0;
            repeat (d - 2) @(negedge clk);
        end else begin
            repeat (d - 1) @(negedge clk);
        end
        findPrimeDone = 1'b1; isPrime = v;
        @(negedge clk);
        findPrimeDone = 1'b0;
        if (spur) begin
            findPrimeDone = 1'b1; isPrime = ~v;
            @(negedge clk);
            findPrimeDone = 1'b0;
        end
        repeat (gdly) @(negedge clk);
        guessValid = 1'b1; guessIsPrime = g;
        @(negedge clk);
        guessValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (levelAdjustEnable !== 1'b0) begin errors++; $display("FAIL reset_lae got=%b exp=0", levelAdjustEnable); end
        checks++; if (primeNumberOut !== 7'd0) begin errors++; $display("FAIL reset_prime got=%0d exp=0", primeNumberOut); end
        checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round got=%0d exp=0", round); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL reset_gameover got=%b exp=0", gameOver); end
        startGame = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got=%b exp=0", busy); end
        startGame = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%b exp=0", busy); end
        checks++; if (adj_pulses !== 0) begin errors++; $display("FAIL release_pulse got=%0d exp=0", adj_pulses); end
    endtask

    task automatic test_idle_ignore();
        int p0;
        p0 = adj_pulses;
        guessValid = 1'b1; guessIsPrime = 1'b1; findPrimeDone = 1'b1; isPrime = 1'b1;
        @(negedge clk);
        guessValid = 1'b0; findPrimeDone = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy got=%b exp=0", busy); end
        checks++; if (score !== 7'd0 || round !== 4'd0) begin errors++; $display("FAIL idle_ignore_state got=%0d/%0d exp=0/0", score, round); end
        checks++; if (adj_pulses !== p0) begin errors++; $display("FAIL idle_ignore_pulse got=%0d exp=%0d", adj_pulses, p0); end
    endtask

    task automatic test_first_round();
        logic tmo;
        logic [6:0] pn;
        startGame = 1'b1;
        @(negedge clk);
        startGame = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b exp=1", busy); end
        play_round(7'd37, 2, 1'b1, 1'b1, 0, 1'b0, tmo, pn);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL first_adjust_seen got=timeout exp=pulse"); end
        checks++; if (pn !== 7'd37) begin errors++; $display("FAIL first_prime_at_adjust got=%0d exp=37", pn); end
        checks++; if (adj_pulses !== 1) begin errors++; $display("FAIL first_pulse_count got=%0d exp=1", adj_pulses); end
        checks++; if (score !== 7'd5) begin errors++; $display("FAIL first_score got=%0d exp=5", score); end
        checks++; if (round !== 4'd1) begin errors++; $display("FAIL first_round got=%0d exp=1", round); end
        checks++; if (score_b !== 7'd40 || pn_b !== 7'd37) begin errors++; $display("FAIL first_b got=%0d/%0d exp=40/37", score_b, pn_b); end
    endtask

    task automatic test_wrong_guess();
        logic tmo;
        logic [6:0] pn, exp_a, exp_b;
        exp_a = PEN ? 7'd0 : 7'd5;
        exp_b = PEN ? 7'd0 : 7'd40;
        play_round(7'd12, 1, 1'b0, 1'b1, 0, 1'b0, tmo, pn);
        checks++; if (tmo !== 1'b0 || pn !== 7'd12) begin errors++; $display("FAIL wrong_prime got=%0d exp=12", pn); end
        checks++; if (score !== exp_a) begin errors++; $display("FAIL wrong_score got=%0d exp=%0d", score, exp_a); end
        checks++; if (round !== 4'd2) begin errors++; $display("FAIL wrong_round got=%0d exp=2", round); end
        checks++; if (score_b !== exp_b) begin errors++; $display("FAIL wrong_score_b got=%0d exp=%0d", score_b, exp_b); end
    endtask

    task automatic test_timeout();
        logic tmo;
        logic [6:0] pn, exp_a;
        exp_a = PEN ? 7'd0 : 7'd5;
        play_round(7'd55, 0, 1'b0, 1'b0, 0, 1'b0, tmo, pn);
        checks++; if (tmo !== 1'b0 || pn !== 7'd55) begin errors++; $display("FAIL timeout_prime got=%0d exp=55", pn); end
        checks++; if (round !== 4'd3) begin errors++; $display("FAIL timeout_round got=%0d exp=3", round); end
        checks++; if (score !== exp_a) begin errors++; $display("FAIL timeout_score got=%0d exp=%0d", score, exp_a); end
    endtask

    task automatic test_done_last_cycle();
        logic tmo;
        logic [6:0] pn, exp_a, exp_b;
        exp_a = PEN ? 7'd5 : 7'd10;
        exp_b = PEN ? 7'd40 : 7'd80;
        play_round(7'd71, 15, 1'b0, 1'b0, 3, 1'b0, tmo, pn);
        checks++; if (round !== 4'd4) begin errors++; $display("FAIL last_cycle_round got=%0d exp=4", round); end
        checks++; if (score !== exp_a) begin errors++; $display("FAIL last_cycle_score got=%0d exp=%0d", score, exp_a); end
        checks++; if (score_b !== exp_b) begin errors++; $display("FAIL last_cycle_score_b got=%0d exp=%0d", score_b, exp_b); end
    endtask

    task automatic test_spurious();
        logic tmo;
        logic [6:0] pn, exp_a, exp_b;
        exp_a = PEN ? 7'd10 : 7'd15;
        exp_b = PEN ? 7'd80 : 7'd99;
        play_round(7'd23, 2, 1'b1, 1'b1, 1, 1'b1, tmo, pn);
        checks++; if (score !== exp_a) begin errors++; $display("FAIL spurious_score got=%0d exp=%0d", score, exp_a); end
        checks++; if (round !== 4'd5) begin errors++; $display("FAIL spurious_round got=%0d exp=5", round); end
        checks++; if (score_b !== exp_b) begin errors++; $display("FAIL spurious_score_b got=%0d exp=%0d", score_b, exp_b); end
    endtask

    task automatic test_full_game();
        logic tmo;
        logic [6:0] pn, exp_a;
        int ntmo;
        ntmo = 0;
        exp_a = PEN ? 7'd35 : 7'd40;
        for (int i = 0; i < 5; i++) begin
            play_round(7'(60 + i), 1, 1'b0, 1'b0, 0, 1'b0, tmo, pn);
            if (tmo) ntmo++;
        end
        checks++; if (ntmo !== 0) begin errors++; $display("FAIL game1_adjust_seen got=%0d timeouts exp=0", ntmo); end
        checks++; if (score !== exp_a) begin errors++; $display("FAIL game1_score got=%0d exp=%0d", score, exp_a); end
        checks++; if (round !== 4'd10) begin errors++; $display("FAIL game1_round got=%0d exp=10", round); end
        checks++; if (gameOver !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL game1_done got=go%b/busy%b exp=go1/busy0", gameOver, busy); end
        checks++; if (score_b !== 7'd99) begin errors++; $display("FAIL game1_sat_b got=%0d exp=99", score_b); end
        checks++; if (busy_b !== 1'b1 || go_b !== 1'b0 || round_b !== 4'd10) begin errors++; $display("FAIL game1_b_state got=busy%b/go%b/r%0d exp=busy1/go0/r10", busy_b, go_b, round_b); end
        checks++; if (adj_pulses !== 10 || adj_pulses_b !== 10) begin errors++; $display("FAIL game1_pulses got=%0d/%0d exp=10/10", adj_pulses, adj_pulses_b); end
    endtask

    task automatic test_back_to_back_game();
        logic tmo;
        logic [6:0] pn;
        int ntmo;
        ntmo = 0;
        startGame = 1'b1;
        @(negedge clk);
        startGame = 1'b0;
        checks++; if (score !== 7'd0 || round !== 4'd0) begin errors++; $display("FAIL restart_clear got=%0d/%0d exp=0/0", score, round); end
        checks++; if (gameOver !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_flags got=go%b/busy%b exp=go0/busy1", gameOver, busy); end
        checks++; if (score_b !== 7'd99 || round_b !== 4'd10) begin errors++; $display("FAIL busy_ignores_start got=%0d/%0d exp=99/10", score_b, round_b); end
        for (int i = 0; i < 10; i++) begin
            play_round(7'(3 + i), 1, 1'b1, 1'b1, 0, 1'b0, tmo, pn);
            if (tmo) ntmo++;
        end
        checks++; if (ntmo !== 0) begin errors++; $display("FAIL game2_adjust_seen got=%0d timeouts exp=0", ntmo); end
        checks++; if (score !== 7'd50 || round !== 4'd10) begin errors++; $display("FAIL game2_result got=%0d/%0d exp=50/10", score, round); end
        checks++; if (gameOver !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL game2_done got=go%b/busy%b exp=go1/busy0", gameOver, busy); end
        repeat (3) @(negedge clk);
        checks++; if (score !== 7'd50 || round !== 4'd10 || gameOver !== 1'b1) begin errors++; $display("FAIL done_hold got=%0d/%0d/go%b exp=50/10/go1", score, round, gameOver); end
    endtask

    task automatic test_reset_mid_game();
        logic tmo;
        logic [6:0] pn;
        int n;
        startGame = 1'b1;
        @(negedge clk);
        startGame = 1'b0;
        play_round(7'd41, 1, 1'b1, 1'b1, 0, 1'b0, tmo, pn);
        checks++; if (score !== 7'd5 || round !== 4'd1) begin errors++; $display("FAIL mid_pre_score got=%0d/%0d exp=5/1", score, round); end
        randomNumber = 7'd99;
        n = 0;
        while (levelAdjustEnable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (levelAdjustEnable !== 1'b1) begin errors++; $display("FAIL mid_adjust_seen got=timeout exp=pulse"); end
        @(negedge clk);
        findPrimeDone = 1'b1; isPrime = 1'b1;
        @(negedge clk);
        findPrimeDone = 1'b0;
        checks++; if (busy !== 1'b1 || primeNumberOut !== 7'd99) begin errors++; $display("FAIL mid_pre_state got=busy%b/%0d exp=busy1/99", busy, primeNumberOut); end
        #3 rst = 1'b0;
        #1;
        checks++; if (score !== 7'd0 || round !== 4'd0) begin errors++; $display("FAIL async_clear got=%0d/%0d exp=0/0", score, round); end
        checks++; if (primeNumberOut !== 7'd0 || levelAdjustEnable !== 1'b0) begin errors++; $display("FAIL async_prime got=%0d/%b exp=0/0", primeNumberOut, levelAdjustEnable); end
        checks++; if (busy !== 1'b0 || gameOver !== 1'b0) begin errors++; $display("FAIL async_flags got=busy%b/go%b exp=0/0", busy, gameOver); end
        guessValid = 1'b1; guessIsPrime = 1'b1;
        repeat (2) @(negedge clk);
        guessValid = 1'b0;
        checks++; if (busy !== 1'b0 || score !== 7'd0) begin errors++; $display("FAIL reset_hold_mid got=busy%b/%0d exp=0/0", busy, score); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        startGame = 1'b0; randomNumber = '0; findPrimeDone = 1'b0; isPrime = 1'b0;
        guessValid = 1'b0; guessIsPrime = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_idle_ignore();
        test_first_round();
        test_wrong_guess();
        test_timeout();
        test_done_last_cycle();
        test_spurious();
        test_full_game();
        test_back_to_back_game();
        test_reset_mid_game();
        test_idle_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, rounds per game (legal 1..15).
REQ-002 Parameter POINTS, default 5, score change per judged guess.
REQ-003 Parameter PRIME_TIMEOUT, default 15, max cycles waited for prime check (legal 2..255).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 startGame  input  1  request new game, level-sensitive.
REQ-007 randomNumber  input  7  candidate number from random source.
REQ-008 findPrimeDone  input  1  prime checker result valid, one-cycle pulse.
REQ-009 isPrime  input  1  checker verdict, valid with findPrimeDone.
REQ-010 guessValid  input  1  player guess strobe.
REQ-011 guessIsPrime  input  1  player guess, valid with guessValid.
REQ-012 levelAdjustEnable  output  1  one-cycle start pulse to level adjust stage.
REQ-013 primeNumberOut  output  7  latched candidate to level adjust stage.
REQ-014 score  output  7  running score, 0..99.
REQ-015 round  output  4  completed rounds in current game.
REQ-016 busy  output  1  high in every state except IDLE and DONE.
REQ-017 gameOver  output  1  high in DONE.

Function
REQ-018 States: IDLE, LOAD, ADJUST, WAIT_PRIME, WAIT_GUESS, SCORE, DONE; all outputs registered/Moore.
REQ-019 IDLE: startGame=1 -> LOAD next cycle, score and round cleared to 0.
REQ-020 LOAD: primeNumberOut <= randomNumber; -> ADJUST.
REQ-021 ADJUST: levelAdjustEnable=1 for exactly this one cycle; timeout counter cleared; -> WAIT_PRIME.
REQ-022 WAIT_PRIME: findPrimeDone=1 -> latch isPrime, -> WAIT_GUESS; counter increments each cycle otherwise.
REQ-023 WAIT_PRIME: counter reaching PRIME_TIMEOUT-1 without findPrimeDone -> SCORE with round marked missed (no score change).
REQ-024 findPrimeDone on the timeout cycle wins over timeout.
REQ-025 WAIT_GUESS: guessValid=1 -> latch guessIsPrime, -> SCORE; waits indefinitely otherwise.
REQ-026 SCORE: guess equal to latched verdict -> score += POINTS, saturating at 99; mismatch per REQ-034; round += 1.
REQ-027 SCORE: new round == NUM_ROUNDS -> DONE, else -> LOAD.
REQ-028 DONE: gameOver=1, score/round held; startGame=1 -> LOAD with score and round cleared.
REQ-029 findPrimeDone outside WAIT_PRIME, guessValid outside WAIT_GUESS, startGame outside IDLE/DONE: ignored.
REQ-030 Minimum round length without waits: LOAD, ADJUST, WAIT_PRIME, WAIT_GUESS, SCORE = 5 cycles.

Reset
REQ-031 rst=0 forces IDLE immediately regardless of clk, including mid-game.
REQ-032 Reset values: levelAdjustEnable 0, primeNumberOut 0, score 0, round 0, busy 0, gameOver 0; internal latches and counter 0.
REQ-033 First edge after rst release evaluates IDLE; no pulse emitted on release.

Configuration
REQ-034 Macro ROUND_PENALTY_EN defined: mismatching guess -> score -= POINTS, floored at 0; undefined: mismatch leaves score unchanged; timeouts never penalised either way.

Verification
REQ-035 Reset then startGame=1, randomNumber=37, findPrimeDone+isPrime=1 two cycles after ADJUST, guess 1 -> primeNumberOut=37, one levelAdjustEnable pulse, score 5, round 1.
REQ-036 Ten correct rounds, POINTS=5 -> score 50, round 10, gameOver=1, busy=0; next startGame -> score 0, round 0.
REQ-037 Score 97, correct guess -> score 99; score 3 wrong guess -> 0 with ROUND_PENALTY_EN, 3 without.
REQ-038 No findPrimeDone for 15 cycles after ADJUST -> SCORE, score unchanged, round+1; done on 15th cycle -> WAIT_GUESS.
REQ-039 rst=0 asserted in WAIT_GUESS between clock edges -> all outputs 0 immediately; guessValid/findPrimeDone pulses in IDLE produce no activity.
